control_unit: RTL and testbench

- Moore-style sequencer for the K&S processor. Drives every control input of data_path (branch, pc_enable, ir_enable, addr_sel, c_sel, operation, write_reg_enable, flags_reg_enable) and the RAM write strobe.
- Consumes decoded_instruction and the registered flags from data_path. Runs a fetch/decode/execute loop, one instruction at a time, until HALT.
- Instantiated beside data_path in the processor top.

---
 rtl/k_and_s_pkg.sv | 96 +++++++++
 rtl/control_unit.sv | 96 +++++++++
 tb/tb_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: instruction decode, sequencer states,
// ULA operation encodings and the bundle of control strobes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'h0,
        I_LOAD   = 4'h1,
        I_STORE  = 4'h2,
        I_MOVE   = 4'h3,
        I_ADD    = 4'h4,
        I_SUB    = 4'h5,
        I_AND    = 4'h6,
        I_OR     = 4'h7,
        I_BRANCH = 4'h8,
        I_BZERO  = 4'h9,
        I_BNZERO = 4'hA,
        I_BNEG   = 4'hB,
        I_BNNEG  = 4'hC,
        I_BOV    = 4'hD,
        I_BNOV   = 4'hE,
        I_HALT   = 4'hF
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        LOAD_1 = 4'd2,
        LOAD_2 = 4'd3,
        STORE  = 4'd4,
        ALU    = 4'd5,
        MOVE   = 4'd6,
        BRANCH = 4'd7,
        HALT   = 4'd8
    } ctrl_state_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic       halt;
    } ctrl_out_type;

    // Strobes for a state; instr only matters for picking the ULA op in ALU.
    function automatic ctrl_out_type ctrl_decode(input ctrl_state_type s,
                                                 input decoded_instruction_type instr);
        ctrl_out_type c;
        c = '0;
        case (s)
            FETCH:  c.ir_enable = 1'b1;
            DECODE: c.pc_enable = 1'b1;
            LOAD_1: c.addr_sel  = 1'b1;
            LOAD_2: begin
                c.addr_sel         = 1'b1;
                c.c_sel            = 1'b1;
                c.write_reg_enable = 1'b1;
            end
            STORE: begin
                c.addr_sel         = 1'b1;
                c.ram_write_enable = 1'b1;
            end
            ALU: begin
                c.write_reg_enable = 1'b1;
                c.flags_reg_enable = 1'b1;
                case (instr)
                    I_SUB:   c.operation = OP_SUB;
                    I_AND:   c.operation = OP_AND;
                    I_OR:    c.operation = OP_OR;
                    default: c.operation = OP_ADD;
                endcase
            end
            MOVE: begin
                c.operation        = OP_OR;
                c.write_reg_enable = 1'b1;
            end
            BRANCH: begin
                c.branch    = 1'b1;
                c.pc_enable = 1'b1;
            end
            HALT:    c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_unit.sv
// K&S processor sequencer: fetch/decode/execute loop driving data_path and
// the RAM write strobe, one instruction at a time until HALT.
//
// state  | meaning
// FETCH  | IR <= RAM[PC]
// DECODE | PC <= PC+1, choose execute state from the decode
// LOAD_1 | RAM addressed by IR field, read data in flight
// LOAD_2 | register <= data_in
// STORE  | RAM[IR field] <= register
// ALU    | register <= ULA result, flags updated
// MOVE   | register <= OR(x,x), flags untouched
// BRANCH | PC <= IR address field
// HALT   | stopped until reset
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_type r_state;
    ctrl_state_type w_next;
    ctrl_out_type   r_ctrl;
    ctrl_out_type   w_ctrl;
    logic           w_unused_uovf;

    assign w_unused_uovf = unsigned_overflow;

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   w_next = LOAD_1;
                    I_STORE:  w_next = STORE;
                    I_MOVE:   w_next = MOVE;
                    I_ADD, I_SUB, I_AND, I_OR: w_next = ALU;
                    I_BRANCH: w_next = BRANCH;
                    I_BZERO:  w_next = zero_op          ? BRANCH : FETCH;
                    I_BNZERO: w_next = !zero_op         ? BRANCH : FETCH;
                    I_BNEG:   w_next = neg_op           ? BRANCH : FETCH;
                    I_BNNEG:  w_next = !neg_op          ? BRANCH : FETCH;
                    I_BOV:    w_next = signed_overflow  ? BRANCH : FETCH;
                    I_BNOV:   w_next = !signed_overflow ? BRANCH : FETCH;
                    I_HALT:   w_next = HALT;
                    default:  w_next = FETCH;
                endcase
            end
            LOAD_1:  w_next = LOAD_2;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    // Strobes are computed for the state being entered so they appear as flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ctrl  <= ctrl_decode(FETCH, I_NOP);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next, decoded_instruction);
        end
    end

    // Reset blanks every strobe immediately, so an interrupted instruction never writes.
    assign w_ctrl = rst_n ? r_ctrl : '0;

    assign branch           = w_ctrl.branch;
    assign pc_enable        = w_ctrl.pc_enable;
    assign ir_enable        = w_ctrl.ir_enable;
    assign addr_sel         = w_ctrl.addr_sel;
    assign c_sel            = w_ctrl.c_sel;
    assign operation        = w_ctrl.operation;
    assign write_reg_enable = w_ctrl.write_reg_enable;
    assign flags_reg_enable = w_ctrl.flags_reg_enable;
    assign ram_write_enable = w_ctrl.ram_write_enable;
    assign halt             = w_ctrl.halt;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected per-cycle strobe vectors are queued
// per instruction and compared cycle by cycle at the falling edge.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst_n;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {halt, branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wr_reg, wr_flags, wr_ram}
    logic [10:0] w_obs;
    assign w_obs = {halt, branch, pc_enable, ir_enable, addr_sel, c_sel,
                    operation, write_reg_enable, flags_reg_enable, ram_write_enable};

    function automatic logic [10:0] vec(input logic h, input logic b, input logic pc,
                                        input logic ir, input logic as, input logic cs,
                                        input logic [1:0] op, input logic wr,
                                        input logic fl, input logic rw);
        return {h, b, pc, ir, as, cs, op, wr, fl, rw};
    endfunction

    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input logic [10:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One queued vector per clock cycle; sample at negedge, drive at posedge+1.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            assert (w_obs === e.v) else begin
                n_err++;
                $error("FAIL %s observed=%b expected=%b", e.tag, w_obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input decoded_instruction_type instr, input logic z,
                       input logic n, input logic v, input string tag);
        logic taken;
        decoded_instruction = instr;
        zero_op             = z;
        neg_op              = n;
        signed_overflow     = v;
        unsigned_overflow   = 1'($urandom_range(0, 1));
        taken = (instr == I_BRANCH) ||
                (instr == I_BZERO  &&  z) || (instr == I_BNZERO && !z) ||
                (instr == I_BNEG   &&  n) || (instr == I_BNNEG  && !n) ||
                (instr == I_BOV    &&  v) || (instr == I_BNOV   && !v);
        push(vec(0,0,0,1,0,0,2'b00,0,0,0), {tag, ":fetch"});
        push(vec(0,0,1,0,0,0,2'b00,0,0,0), {tag, ":decode"});
        case (instr)
            I_LOAD: begin
                push(vec(0,0,0,0,1,0,2'b00,0,0,0), {tag, ":load1"});
                push(vec(0,0,0,0,1,1,2'b00,1,0,0), {tag, ":load2"});
            end
            I_STORE: push(vec(0,0,0,0,1,0,2'b00,0,0,1), {tag, ":store"});
            I_MOVE:  push(vec(0,0,0,0,0,0,2'b11,1,0,0), {tag, ":move"});
            I_ADD:   push(vec(0,0,0,0,0,0,2'b00,1,1,0), {tag, ":alu"});
            I_SUB:   push(vec(0,0,0,0,0,0,2'b01,1,1,0), {tag, ":alu"});
            I_AND:   push(vec(0,0,0,0,0,0,2'b10,1,1,0), {tag, ":alu"});
            I_OR:    push(vec(0,0,0,0,0,0,2'b11,1,1,0), {tag, ":alu"});
            I_HALT: begin
                for (int k = 0; k < 22; k++)
                    push(vec(1,0,0,0,0,0,2'b00,0,0,0), {tag, ":halt"});
            end
            default: begin
                if (taken)
                    push(vec(0,1,1,0,0,0,2'b00,0,0,0), {tag, ":branch"});
            end
        endcase
        drain();
    endtask

    initial begin
        rst_n               = 1'b0;
        decoded_instruction = I_NOP;
        zero_op             = 1'b0;
        neg_op              = 1'b0;
        unsigned_overflow   = 1'b0;
        signed_overflow     = 1'b0;

        for (int k = 0; k < 3; k++)
            push(vec(0,0,0,0,0,0,2'b00,0,0,0), "reset_hold");
        drain();
        rst_n = 1'b1;

        run(I_NOP,   0, 0, 0, "nop");
        run(I_ADD,   1, 1, 1, "add");
        run(I_SUB,   0, 0, 0, "sub");
        run(I_AND,   0, 1, 0, "and");
        run(I_OR,    1, 0, 1, "or");
        run(I_MOVE,  0, 0, 0, "move");
        run(I_LOAD,  0, 0, 0, "load");
        run(I_STORE, 1, 1, 1, "store");
        run(I_BRANCH,0, 0, 0, "branch");

        // Each conditional in both polarities, unrelated flags set to the opposite.
        run(I_BZERO,  1, 0, 0, "bzero_t");
        run(I_BZERO,  0, 1, 1, "bzero_n");
        run(I_BNZERO, 0, 1, 1, "bnzero_t");
        run(I_BNZERO, 1, 0, 0, "bnzero_n");
        run(I_BNEG,   0, 1, 0, "bneg_t");
        run(I_BNEG,   1, 0, 1, "bneg_n");
        run(I_BNNEG,  1, 0, 1, "bnneg_t");
        run(I_BNNEG,  0, 1, 0, "bnneg_n");
        run(I_BOV,    0, 0, 1, "bov_t");
        run(I_BOV,    1, 1, 0, "bov_n");
        run(I_BNOV,   1, 1, 0, "bnov_t");
        run(I_BNOV,   0, 0, 1, "bnov_n");

        // Reset while in LOAD_1: strobes blanked, no register write, restart at FETCH.
        decoded_instruction = I_LOAD;
        push(vec(0,0,0,1,0,0,2'b00,0,0,0), "midrst:fetch");
        push(vec(0,0,1,0,0,0,2'b00,0,0,0), "midrst:decode");
        drain();
        rst_n = 1'b0;
        push(vec(0,0,0,0,0,0,2'b00,0,0,0), "midrst:load1_in_reset");
        drain();
        rst_n = 1'b1;
        run(I_NOP, 0, 0, 0, "after_midrst");

        run(I_HALT, 0, 0, 0, "halt");
        rst_n = 1'b0;
        push(vec(0,0,0,0,0,0,2'b00,0,0,0), "halt_reset");
        drain();
        rst_n = 1'b1;
        run(I_NOP, 0, 0, 0, "after_halt");
        run(I_ADD, 0, 0, 0, "add_after_halt");
        run(I_NOP, 0, 0, 0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
